// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared control-bundle layout, ALU op codes and MDU timer states
package ctrl_pipe_pkg;
  localparam int ALU_OP_W  = 4;
  localparam int DM_OP_W   = 3;
  localparam int EXT_OP_W  = 2;
  localparam int PC_OP_W   = 3;
  localparam int REG_SRC_W = 2;
  localparam int REG_DST_W = 2;
  localparam int REG_IN_W  = 2;
  localparam int CTRL_PAD_W = 10;
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR, ALU_OP_NOR,
    ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_LUI,
    ALU_OP_MUL, ALU_OP_MULU, ALU_OP_DIV, ALU_OP_DIVU
  } alu_op_e;
  typedef struct packed {
    logic [CTRL_PAD_W-1:0] pad;
    alu_op_e               alu_op;
    logic                  alu_src;
    logic [DM_OP_W-1:0]    dm_op;
    logic                  dm_wr;
    logic                  dm_rd;
    logic [EXT_OP_W-1:0]   ext_op;
    logic [PC_OP_W-1:0]    pc_op;
    logic [REG_SRC_W-1:0]  reg_src;
    logic [REG_DST_W-1:0]  reg_dst;
    logic                  reg_wr;
    logic [REG_IN_W-1:0]   reg_in;
  } ctrl_t;
  localparam int CTRL_W_DEF = $bits(ctrl_t);
  typedef enum logic {RUN, MDU_WAIT} mdu_state_e;
endpackage

// File: rtl/mdu_timer.sv
// mdu_timer: RUN/MDU_WAIT FSM with 6-bit down-counter timing multi-cycle mul/div occupancy of EX
module mdu_timer
  import ctrl_pipe_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic start,
  input  logic is_div,
  output logic busy
);
  mdu_state_e state_q;
  logic [5:0] cnt_q;
  logic [5:0] load;
  assign load = is_div ? 6'(DIV_CYCLES - 1) : 6'(MUL_CYCLES - 1);
  assign busy = state_q == MDU_WAIT;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else if (state_q == MDU_WAIT) begin
      cnt_q   <= cnt_q - 6'd1;
      state_q <= cnt_q == 6'd1 ? RUN : MDU_WAIT;
    end else if (start) begin
      cnt_q   <= load;
      state_q <= load != 6'd0 ? MDU_WAIT : RUN;
    end
  end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID->EX control register with load-use bubbling, flush and multi-cycle MDU stall
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic              in_uses_rt,
  input  logic [4:0]        in_dst,
  input  logic              in_dm_rd,
  input  logic              in_mul,
  input  logic              in_div,
  input  logic              flush,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [4:0]        ex_dst,
  output logic              ex_dm_rd,
  output logic              stall,
  output logic              mdu_busy
);
  logic hazard;
  logic start;
  assign hazard = ex_valid & ex_dm_rd & (ex_dst != 5'd0) & in_valid &
                  ((ex_dst == in_rs) | (in_uses_rt & (ex_dst == in_rt)));
  assign start  = in_valid & (in_mul | in_div) & ~hazard & ~flush & ~mdu_busy;
  assign stall  = mdu_busy | hazard;
  mdu_timer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .start (start),
    .is_div(in_div),
    .busy  (mdu_busy)
  );
  always_ff @(posedge clk) begin
    if (rst || flush || (!mdu_busy && hazard)) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_dst   <= '0;
      ex_dm_rd <= 1'b0;
    end else if (!mdu_busy) begin
      ex_valid <= in_valid;
      ex_ctrl  <= in_ctrl;
      ex_dst   <= in_dst;
      ex_dm_rd <= in_dm_rd;
    end
  end
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: scoreboard bench for ctrl_pipe hazards, MDU timing, flush and reset
module tb_ctrl_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, in_uses_rt, in_dm_rd, in_mul, in_div, flush;
  logic [31:0] in_ctrl;
  logic [4:0] in_rs, in_rt, in_dst;
  logic a_valid, a_dm, a_stall, a_busy, b_valid, b_dm, b_stall, b_busy;
  logic [31:0] a_ctrl, b_ctrl;
  logic [4:0] a_dst, b_dst;
  int errs = 0;
  int checks = 0;
  typedef struct {
    logic v;
    logic [31:0] c;
    logic [4:0] d;
    logic m;
    logic b;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  ctrl_pipe #(.CTRL_W(32), .MUL_CYCLES(4), .DIV_CYCLES(32)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_rs(in_rs),
    .in_rt(in_rt), .in_uses_rt(in_uses_rt), .in_dst(in_dst), .in_dm_rd(in_dm_rd),
    .in_mul(in_mul), .in_div(in_div), .flush(flush), .ex_valid(a_valid),
    .ex_ctrl(a_ctrl), .ex_dst(a_dst), .ex_dm_rd(a_dm), .stall(a_stall), .mdu_busy(a_busy)
  );
  ctrl_pipe #(.CTRL_W(32), .MUL_CYCLES(4), .DIV_CYCLES(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_rs(in_rs),
    .in_rt(in_rt), .in_uses_rt(in_uses_rt), .in_dst(in_dst), .in_dm_rd(in_dm_rd),
    .in_mul(in_mul), .in_div(in_div), .flush(flush), .ex_valid(b_valid),
    .ex_ctrl(b_ctrl), .ex_dst(b_dst), .ex_dm_rd(b_dm), .stall(b_stall), .mdu_busy(b_busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] d, input logic ld, input logic mul,
                       input logic dv, input logic fl);
    in_valid = v; in_ctrl = c; in_rs = rs; in_rt = rt; in_uses_rt = urt;
    in_dst = d; in_dm_rd = ld; in_mul = mul; in_div = dv; flush = fl;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic push(input logic v, input logic [31:0] c, input logic [4:0] d, input logic m, input logic b);
    exp_t e;
    e.v = v; e.c = c; e.d = d; e.m = m; e.b = b;
    q.push_back(e);
  endtask
  task automatic stall_is(input string tag, input logic exp);
    #1;
    chk(tag, a_stall, exp);
  endtask
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      errs++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_valid"}, a_valid, e.v);
      chk({tag, "_ctrl"}, a_ctrl, e.c);
      chk({tag, "_dst"}, a_dst, e.d);
      chk({tag, "_dm_rd"}, a_dm, e.m);
      chk({tag, "_busy"}, a_busy, e.b);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    int na, nb;
    do_reset();
    chk("rst_valid", a_valid, 0);
    chk("rst_ctrl", a_ctrl, 0);
    chk("rst_dst", a_dst, 0);
    chk("rst_dm_rd", a_dm, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_stall", a_stall, 0);
    drive(1, 32'hA1, 1, 0, 0, 8, 1, 0, 0, 0);
    stall_is("lw8_stall", 0);
    push(1, 32'hA1, 8, 1, 0);
    tick("lw8");
    drive(1, 32'hB2, 8, 1, 1, 9, 0, 0, 0, 0);
    stall_is("add_hz_stall", 1);
    push(0, 0, 0, 0, 0);
    tick("bubble");
    stall_is("add_go_stall", 0);
    push(1, 32'hB2, 9, 0, 0);
    tick("add");
    drive(1, 32'hA5, 2, 0, 0, 5, 1, 0, 0, 0);
    push(1, 32'hA5, 5, 1, 0);
    tick("lw5");
    drive(1, 32'hB6, 2, 5, 0, 6, 0, 0, 0, 0);
    stall_is("rt_unused_stall", 0);
    push(1, 32'hB6, 6, 0, 0);
    tick("rt_unused");
    drive(1, 32'hA7, 2, 0, 0, 5, 1, 0, 0, 0);
    push(1, 32'hA7, 5, 1, 0);
    tick("lw5b");
    drive(1, 32'hB8, 2, 5, 1, 7, 0, 0, 0, 0);
    stall_is("rt_used_stall", 1);
    push(0, 0, 0, 0, 0);
    tick("rt_bubble");
    stall_is("rt_go_stall", 0);
    push(1, 32'hB8, 7, 0, 0);
    tick("rt_used");
    drive(1, 32'hC3, 2, 0, 0, 0, 1, 0, 0, 0);
    push(1, 32'hC3, 0, 1, 0);
    tick("lw0");
    drive(1, 32'hD4, 0, 0, 1, 10, 0, 0, 0, 0);
    stall_is("r0_stall", 0);
    push(1, 32'hD4, 10, 0, 0);
    tick("r0_reader");
    drive(1, 32'hE5, 3, 4, 1, 11, 0, 0, 1, 0);
    stall_is("div_stall", 0);
    push(1, 32'hE5, 11, 0, 1);
    tick("div");
    drive(1, 32'hF6, 3, 0, 0, 12, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      stall_is("div_wait_stall", 1);
      push(1, 32'hE5, 11, 0, 1);
      tick("div_wait");
    end
    stall_is("div_last_stall", 1);
    push(1, 32'hE5, 11, 0, 0);
    tick("div_end");
    stall_is("post_div_stall", 0);
    push(1, 32'hF6, 12, 0, 0);
    tick("post_div");
    do_reset();
    drive(1, 32'h11, 3, 4, 1, 13, 0, 1, 0, 0);
    push(1, 32'h11, 13, 0, 1);
    tick("mul");
    drive(1, 32'h22, 3, 0, 0, 14, 0, 0, 0, 0);
    stall_is("mul_wait_stall", 1);
    push(1, 32'h11, 13, 0, 1);
    tick("mul_wait");
    flush = 1'b1;
    push(0, 0, 0, 0, 0);
    tick("flush");
    stall_is("flush_stall", 0);
    flush = 1'b0;
    stall_is("post_flush_stall", 0);
    push(1, 32'h22, 14, 0, 0);
    tick("post_flush");
    drive(1, 32'hE9, 3, 4, 1, 15, 0, 0, 1, 0);
    push(1, 32'hE9, 15, 0, 1);
    tick("div2");
    idle();
    for (int i = 0; i < 21; i++) begin
      push(1, 32'hE9, 15, 0, 1);
      tick("div2_wait");
    end
    rst = 1'b1;
    push(0, 0, 0, 0, 0);
    tick("rst_mid");
    rst = 1'b0;
    stall_is("rst_mid_stall", 0);
    push(0, 0, 0, 0, 0);
    tick("post_rst");
    do_reset();
    drive(1, 32'h33, 3, 4, 1, 16, 0, 1, 1, 0);
    na = 0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      idle();
      na += int'(a_busy);
      nb += int'(b_busy);
    end
    chk("both_busy_div32", 64'(na), 31);
    chk("both_busy_div8", 64'(nb), 7);
    chk("sb_drained", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter CTRL_W, default 32: width of the packed decoded-control bundle (alu_op, alu_src, dm_op, dm_wr, dm_rd, ext_op, pc_op, reg_src, reg_dst, reg_wr, reg_in).
REQ-002 SHALL have parameter MUL_CYCLES, default 4: EX occupancy of mul/muh/mulu/muhu; legal range 1..64.
REQ-003 SHALL have parameter DIV_CYCLES, default 32: EX occupancy of div/mod/divu/modu; legal range 1..64.
REQ-004 SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-005 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  ID holds a decoded instruction
- in_ctrl  in  CTRL_W  decoded control bundle
- in_rs  in  5  source register rs
- in_rt  in  5  source register rt
- in_uses_rt  in  1  instruction reads rt
- in_dst  in  5  resolved destination register (rd, rt or 31)
- in_dm_rd  in  1  instruction is a load
- in_mul  in  1  multiply-family op
- in_div  in  1  divide-family op
- flush  in  1  taken branch/jump resolved in EX
- ex_valid  out  1  EX holds a real instruction
- ex_ctrl  out  CTRL_W  registered bundle
- ex_dst  out  5  registered destination
- ex_dm_rd  out  1  registered load flag
- stall  out  1  hold PC and IF/ID this cycle
- mdu_busy  out  1  multi-cycle op occupying EX

Function
REQ-006 SHALL keep the EX register set {ex_valid, ex_ctrl, ex_dst, ex_dm_rd}; all outputs except stall are registered.
REQ-007 SHALL run a two-state FSM: RUN and MDU_WAIT, plus a 6-bit down-counter cnt.
REQ-008 SHALL, in RUN, when in_valid & (in_mul | in_div) & no load-use hazard & !flush, accept the instruction into EX, load cnt with (in_div ? DIV_CYCLES : MUL_CYCLES) - 1, and enter MDU_WAIT if that value is non-zero.
REQ-009 SHALL give in_div priority over in_mul when both are set.
REQ-010 SHALL, in MDU_WAIT, hold the EX register unchanged, decrement cnt each cycle, and return to RUN on the cycle cnt reaches 0.
REQ-011 SHALL drive mdu_busy = (state == MDU_WAIT).
REQ-012 SHALL detect a load-use hazard = ex_valid & ex_dm_rd & ex_dst != 0 & in_valid & (ex_dst == in_rs | (in_uses_rt & ex_dst == in_rt)).
REQ-013 SHALL, on a load-use hazard in RUN, load a bubble into EX (ex_valid = 0, ex_ctrl = 0, ex_dm_rd = 0, ex_dst = 0); the hazard therefore clears after exactly 1 stall cycle.
REQ-014 SHALL drive stall = mdu_busy | load_use_hazard, combinationally, as a same-cycle output.
REQ-015 SHALL otherwise, in RUN, load in_* into EX, with ex_valid = in_valid.
REQ-016 SHALL apply update priority per edge as rst > flush > MDU_WAIT hold > load-use bubble > accept.
REQ-017 SHALL, on flush, bubble EX, zero cnt, and force RUN, aborting any in-flight MDU op.
REQ-018 SHALL treat flush and an in_valid instruction in the same cycle by discarding the instruction.
REQ-019 SHALL perform no hazard check against register 0; a load to $0 never stalls.
REQ-020 SHALL, with MUL_CYCLES = 1 or DIV_CYCLES = 1, never enter MDU_WAIT, so the op behaves as single-cycle.

Reset
REQ-021 SHALL, on rst, set state = RUN, cnt = 0, ex_valid = 0, ex_ctrl = 0, ex_dst = 0, ex_dm_rd = 0; stall and mdu_busy therefore read 0 in the cycle after rst.
REQ-022 SHALL, with rst asserted mid-MDU_WAIT, abort the op with no residual stall.

Structure
REQ-023 SHALL take bundle field widths/offsets, ALU_OP_* codes and the CTRL_W default from the shared common definitions include.
REQ-024 SHALL instantiate one sub-module, mdu_timer (counter plus RUN/MDU_WAIT FSM); hazard logic and the EX register stay in ctrl_pipe.

Verification
REQ-025 SHALL cover: lw to $8 followed by add $9,$8,$1 -> stall = 1 for exactly 1 cycle, one bubble in EX, then add in EX.
REQ-026 SHALL cover: lw to $0 followed by a reader of $0 -> stall never asserted.
REQ-027 SHALL cover: div with DIV_CYCLES = 32 -> mdu_busy high 31 cycles, EX held, next instruction enters EX on cycle 32.
REQ-028 SHALL cover: mul with MUL_CYCLES = 4 and flush asserted on cycle 2 -> next cycle ex_valid = 0, mdu_busy = 0, stall = 0.
REQ-029 SHALL cover: rst asserted during MDU_WAIT (cnt = 10) -> next cycle all outputs 0, state RUN.
REQ-030 SHALL cover: in_div and in_mul both set with MUL_CYCLES = 4, DIV_CYCLES = 8 -> mdu_busy high 7 cycles.
